mips_memory: RTL and testbench
==============================

# mips_memory

Unified instruction/data memory that responds to the multicycle `mips` core's memory interface, plus a boot-load front end. After reset it holds the core in reset while a host streams program words into the array over a valid/ready port. It then releases the core and serves its reads and writes, with one memory-mapped output register. It sits beside `mips` at the top level: `mips` drives `memAddr`, `MemWrite` and `writeMemData`, and this block returns `memData`.

## Interface
- `WORDS`, 1024: array depth in 32-bit words; power of two, ≤ 16383.
- `ADDR_W`, 16: byte-address width; matches the core's `memAddr`.
- `IO_ADDR`, 16'hFFFC: byte address of the output register.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `memAddr`  in  ADDR_W  byte address from the core.
- `MemWrite`  in  1  core write strobe.
- `writeMemData`  in  32  core write data.
- `memData`  out  32  read data to the core.
- `load_valid`  in  1  host has a program word.
- `load_data`  in  32  program word.
- `load_last`  in  1  marks the final word; qualified by `load_valid`.
- `load_ready`  out  1  block accepts a word this cycle.
- `cpu_reset`  out  1  hold reset for `mips`.
- `io_out`  out  32  output register.
- `io_strobe`  out  1  one-cycle pulse on every write to `io_out`.

## Operation
- **FSM states:** LOAD, RUN. Reset forces LOAD with `load_ptr`=0.
- **Reset values:**
  - `cpu_reset`=1, `load_ready`=1 (combinational from the state), `io_out`=0, `io_strobe`=0.
  - Array contents are not cleared.
- **LOAD:**
  - Beat accept = `load_valid` & `load_ready`.
  - On accept: mem[`load_ptr`] ← `load_data`, then `load_ptr`++.
  - Go to RUN on an accept with `load_last`=1, or on an accept when `load_ptr`=WORDS-1.
  - Core accesses are ignored.
- **RUN:**
  - `load_ready`=0 and `cpu_reset`=0.
  - RUN is left only via `reset`.
- **Address decode:**
  - Word index = `memAddr[ADDR_W-1:2]`; `memAddr[1:0]` is ignored (word-aligned only).
  - Word index == IO_ADDR>>2: the IO register.
  - Word index < WORDS: the array.
  - Otherwise: unmapped.
- **Reads** are combinational from `memAddr`:
  - Array: mem[index].
  - IO: `io_out`.
  - Unmapped: 32'h0.
  - During LOAD, `memData` still reflects the array.
- **Writes:** when `MemWrite` is high in RUN at the edge:
  - Array: mem[index] ← `writeMemData`.
  - IO: `io_out` ← `writeMemData`, and `io_strobe`=1 for the next cycle only.
  - Unmapped: dropped silently.

## Timing
- Read latency is 0 cycles: `memData` is valid in the same cycle as `memAddr`, which the multicycle core requires for IR/MDR latching.
- Write takes effect at the edge. In the cycle of a same-address write, `memData` shows the old value; in the next cycle it shows the new value.
- Load throughput is one word per cycle while `load_valid` is held.
- `cpu_reset` deasserts in the cycle after the final accepted beat.
- A `load_valid` beat arriving after entry to RUN is not accepted.
- `reset` mid-load or mid-run:
  - Returns to LOAD with `load_ptr`=0 and `cpu_reset`=1.
  - Memory keeps prior contents; a reload overwrites from word 0.
- `io_strobe` never asserts during LOAD or reset.

## Structure
- Package `mips_mem_pkg` holds the state enum (LOAD, RUN), IO_ADDR default and the unmapped read value.
- Submodule `mips_mem_loader` holds the LOAD/RUN FSM, `load_ptr`, `load_ready` and `cpu_reset`. It exports the write-enable, index and data for load beats.
- The top holds the array, write mux (loader vs core), decode and IO register.

## Test plan
- **Basic load:** stream 4 words 32'h1000_0001..04, `load_last` on the 4th. Required: mem[0..3] match; `cpu_reset` falls the cycle after beat 4; `load_ready`=0 afterwards.
- **Gapped load:** toggle `load_valid` 1/0 over 3 words. Required: only valid cycles advance `load_ptr`; contents are contiguous at words 0..2.
- **Auto-finish (WORDS=8), no `load_last`:** stream 10 beats. Required: 8 accepted, RUN entered after the 8th, beats 9–10 not accepted.
- **RUN access:**
  - Write 32'hDEADBEEF to 0x0010 and read back next cycle. Required: `memData`=32'hDEADBEEF.
  - Read 0x0013. Required: same word.
  - Write to 0x8000 (unmapped). Required: no change; reads return 0.
- **IO:** write 32'h0000_00A5 to 0xFFFC. Required: `io_out`=32'h0000_00A5, `io_strobe` high for exactly 1 cycle, read of 0xFFFC returns 32'h0000_00A5.
- **Reset mid-load:** after 2 beats, pulse `reset` asynchronously. Required:
  - `cpu_reset`=1, `io_out`=0 immediately.
  - A reload writes from word 0.
  - Old word 2 is preserved if not reloaded.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the unified MIPS instruction/data memory.
// Imported by the loader sub-module and the memory top.
package mips_mem_pkg;

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFC;
    localparam logic [31:0] UNMAPPED_RDATA  = 32'h0000_0000;

endpackage

// File: rtl/mips_memory_if.sv
// Core memory bus plus host boot-load stream seen by mips_memory.
// The master side is the core and host; the slave side is the memory.
interface mips_memory_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] memAddr;
    logic              MemWrite;
    logic [31:0]       writeMemData;
    logic [31:0]       memData;

    logic              load_valid;
    logic [31:0]       load_data;
    logic              load_last;
    logic              load_ready;

    modport master (
        output memAddr, MemWrite, writeMemData, load_valid, load_data, load_last,
        input  memData, load_ready
    );

    modport slave (
        input  memAddr, MemWrite, writeMemData, load_valid, load_data, load_last,
        output memData, load_ready
    );
endinterface

// File: rtl/mips_mem_loader.sv
// Boot-load sequencer: holds the core in reset while program words stream in,
// then hands the memory over to the core until the next reset.
module mips_mem_loader
    import mips_mem_pkg::*;
#(
    parameter  int WORDS = 1024,
    localparam int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_valid,
    input  logic          load_last,
    input  logic [31:0]   load_data,
    output logic          load_ready,
    output logic          cpu_reset,
    output logic          run,
    output logic          ld_we,
    output logic [AW-1:0] ld_idx,
    output logic [31:0]   ld_data
);

    localparam logic [AW-1:0] LAST_PTR = AW'(WORDS - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] load_ptr_q, load_ptr_d;
    logic          accept;

    assign load_ready = (state_q == ST_LOAD);
    assign cpu_reset  = (state_q == ST_LOAD);
    assign run        = (state_q == ST_RUN);
    assign accept     = load_valid & load_ready;

    assign ld_we   = accept;
    assign ld_idx  = load_ptr_q;
    assign ld_data = load_data;

    always_comb begin
        state_d    = state_q;
        load_ptr_d = load_ptr_q;
        if (accept) begin
            load_ptr_d = load_ptr_q + 1'b1;
            // A full array ends the load even if the host never flags the last word.
            if (load_last || (load_ptr_q == LAST_PTR)) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_LOAD;
            load_ptr_q <= '0;
        end else begin
            state_q    <= state_d;
            load_ptr_q <= load_ptr_d;
        end
    end

endmodule

// File: rtl/mips_memory.sv
// Unified instruction/data memory for the multicycle mips core: zero-latency
// reads, edge writes, one memory-mapped output register and a boot loader.
module mips_memory
    import mips_mem_pkg::*;
#(
    parameter int                WORDS   = 1024,
    parameter int                ADDR_W  = 16,
    parameter logic [ADDR_W-1:0] IO_ADDR = ADDR_W'(IO_ADDR_DEFAULT)
) (
    input  logic           clk,
    input  logic           reset,
    mips_memory_if.slave   bus,
    output logic           cpu_reset,
    output logic [31:0]    io_out,
    output logic           io_strobe
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int AW    = $clog2(WORDS);

    logic [31:0]    mem_q [WORDS];
    logic [31:0]    io_out_q, io_out_d;
    logic           io_strobe_q, io_strobe_d;

    logic [IDX_W-1:0] word_idx;
    logic           is_io, in_array, core_we, run;
    logic           ld_we;
    logic [AW-1:0]  ld_idx;
    logic [31:0]    ld_data;
    logic           mem_we;
    logic [AW-1:0]  mem_widx;
    logic [31:0]    mem_wdata;
    logic           unused_addr_bits;

    mips_mem_loader #(.WORDS(WORDS)) u_loader (
        .clk        (clk),
        .reset      (reset),
        .load_valid (bus.load_valid),
        .load_last  (bus.load_last),
        .load_data  (bus.load_data),
        .load_ready (bus.load_ready),
        .cpu_reset  (cpu_reset),
        .run        (run),
        .ld_we      (ld_we),
        .ld_idx     (ld_idx),
        .ld_data    (ld_data)
    );

    assign word_idx         = bus.memAddr[ADDR_W-1:2];
    assign unused_addr_bits = ^bus.memAddr[1:0];
    assign is_io            = (word_idx == IO_ADDR[ADDR_W-1:2]);
    assign in_array         = !is_io && (word_idx < IDX_W'(WORDS));
    assign core_we          = run & bus.MemWrite;

    // Loader and core never write in the same cycle: core writes only count in RUN.
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = ld_idx;
        mem_wdata = ld_data;
        if (ld_we) begin
            mem_we = 1'b1;
        end else if (core_we && in_array) begin
            mem_we    = 1'b1;
            mem_widx  = word_idx[AW-1:0];
            mem_wdata = bus.writeMemData;
        end
    end

    always_comb begin
        io_out_d    = io_out_q;
        io_strobe_d = 1'b0;
        if (core_we && is_io) begin
            io_out_d    = bus.writeMemData;
            io_strobe_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            io_out_q    <= '0;
            io_strobe_q <= 1'b0;
        end else begin
            io_out_q    <= io_out_d;
            io_strobe_q <= io_strobe_d;
        end
    end

    // Contents survive reset so a partial reload keeps the untouched words.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_widx] <= mem_wdata;
        end
    end

    always_comb begin
        bus.memData = UNMAPPED_RDATA;
        if (is_io) begin
            bus.memData = io_out_q;
        end else if (in_array) begin
            bus.memData = mem_q[word_idx[AW-1:0]];
        end
    end

    assign io_out    = io_out_q;
    assign io_strobe = io_strobe_q;

endmodule

// File: tb/tb_mips_memory.sv
// Directed bench for mips_memory: boot load, gapped load, auto-finish on a
// small array, core reads/writes, IO register and resets mid-run/mid-load.
module tb_mips_memory;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b;
    logic        cpu_reset_a, cpu_reset_b;
    logic [31:0] io_out_a, io_out_b;
    logic        io_strobe_a, io_strobe_b;

    int n_assert = 0;
    int n_fail   = 0;

    mips_memory_if #(.ADDR_W(16)) bus_a ();
    mips_memory_if #(.ADDR_W(16)) bus_b ();

    mips_memory #(.WORDS(1024), .ADDR_W(16), .IO_ADDR(16'hFFFC)) dut_a (
        .clk       (clk),
        .reset     (rst_a),
        .bus       (bus_a.slave),
        .cpu_reset (cpu_reset_a),
        .io_out    (io_out_a),
        .io_strobe (io_strobe_a)
    );

    mips_memory #(.WORDS(8), .ADDR_W(16), .IO_ADDR(16'hFFFC)) dut_b (
        .clk       (clk),
        .reset     (rst_b),
        .bus       (bus_b.slave),
        .cpu_reset (cpu_reset_b),
        .io_out    (io_out_b),
        .io_strobe (io_strobe_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_a(input logic [15:0] addr, input logic [31:0] exp, input string tag);
        bus_a.memAddr  = addr;
        bus_a.MemWrite = 1'b0;
        #1;
        chk(tag, bus_a.memData, exp);
    endtask

    task automatic rd_b(input logic [15:0] addr, input logic [31:0] exp, input string tag);
        bus_b.memAddr  = addr;
        bus_b.MemWrite = 1'b0;
        #1;
        chk(tag, bus_b.memData, exp);
    endtask

    logic gap_valid [5];

    initial begin
        gap_valid = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.memAddr = '0; bus_a.MemWrite = 1'b0; bus_a.writeMemData = '0;
        bus_a.load_valid = 1'b0; bus_a.load_data = '0; bus_a.load_last = 1'b0;
        bus_b.memAddr = '0; bus_b.MemWrite = 1'b0; bus_b.writeMemData = '0;
        bus_b.load_valid = 1'b0; bus_b.load_data = '0; bus_b.load_last = 1'b0;

        #3;
        chk("rst_cpu_reset", cpu_reset_a, 32'd1);
        chk("rst_load_ready", bus_a.load_ready, 32'd1);
        chk("rst_io_out", io_out_a, 32'h0);
        chk("rst_io_strobe", io_strobe_a, 32'd0);
        @(posedge clk);
        tick();
        rst_a = 1'b0;

        // Basic load of four words, last flagged on the fourth
        for (int i = 0; i < 4; i++) begin
            bus_a.load_valid = 1'b1;
            bus_a.load_data  = 32'h1000_0001 + i;
            bus_a.load_last  = (i == 3);
            #1;
            chk($sformatf("basic_ready_%0d", i), bus_a.load_ready, 32'd1);
            chk($sformatf("basic_cpu_reset_%0d", i), cpu_reset_a, 32'd1);
            tick();
        end
        bus_a.load_valid = 1'b0;
        bus_a.load_last  = 1'b0;
        #1;
        chk("basic_cpu_reset_released", cpu_reset_a, 32'd0);
        chk("basic_ready_low", bus_a.load_ready, 32'd0);
        chk("basic_io_strobe", io_strobe_a, 32'd0);
        for (int i = 0; i < 4; i++) begin
            rd_a(16'(i * 4), 32'h1000_0001 + i, $sformatf("basic_word_%0d", i));
        end

        // Beat offered after entry to RUN is not accepted
        tick();
        bus_a.load_valid = 1'b1;
        bus_a.load_data  = 32'hFFFF_FFFF;
        #1;
        chk("late_beat_ready", bus_a.load_ready, 32'd0);
        tick();
        bus_a.load_valid = 1'b0;

        // Reset, then gapped load of three words
        rst_a = 1'b1;
        #2;
        rst_a = 1'b0;
        tick();
        chk("gap_cpu_reset", cpu_reset_a, 32'd1);
        begin
            int k;
            k = 0;
            for (int i = 0; i < 5; i++) begin
                bus_a.load_valid = gap_valid[i];
                bus_a.load_data  = gap_valid[i] ? (32'h2000_0001 + k) : 32'hFFFF_FFFF;
                bus_a.load_last  = (i == 4);
                if (gap_valid[i]) k++;
                tick();
            end
        end
        bus_a.load_valid = 1'b0;
        bus_a.load_last  = 1'b0;
        #1;
        chk("gap_cpu_reset_released", cpu_reset_a, 32'd0);
        for (int i = 0; i < 3; i++) begin
            rd_a(16'(i * 4), 32'h2000_0001 + i, $sformatf("gap_word_%0d", i));
        end
        rd_a(16'h000C, 32'h1000_0004, "gap_word_3_kept");

        // Same-address write: old value this cycle, new value next cycle
        tick();
        bus_a.memAddr      = 16'h0000;
        bus_a.MemWrite     = 1'b1;
        bus_a.writeMemData = 32'h1111_2222;
        #1;
        chk("rdw_old_value", bus_a.memData, 32'h2000_0001);
        tick();
        rd_a(16'h0000, 32'h1111_2222, "rdw_new_value");

        tick();
        bus_a.memAddr      = 16'h0010;
        bus_a.MemWrite     = 1'b1;
        bus_a.writeMemData = 32'hDEAD_BEEF;
        tick();
        rd_a(16'h0010, 32'hDEAD_BEEF, "run_wr_0010");
        rd_a(16'h0013, 32'hDEAD_BEEF, "run_rd_0013");

        // Unmapped write must not alias into the array
        tick();
        bus_a.memAddr      = 16'h8000;
        bus_a.MemWrite     = 1'b1;
        bus_a.writeMemData = 32'h5555_5555;
        tick();
        rd_a(16'h8000, 32'h0, "unmapped_read");
        rd_a(16'h0000, 32'h1111_2222, "unmapped_no_alias_w0");
        rd_a(16'h0010, 32'hDEAD_BEEF, "unmapped_no_alias_w4");
        chk("unmapped_no_strobe", io_strobe_a, 32'd0);

        // IO register
        tick();
        bus_a.memAddr      = 16'hFFFC;
        bus_a.MemWrite     = 1'b1;
        bus_a.writeMemData = 32'h0000_00A5;
        #1;
        chk("io_strobe_before", io_strobe_a, 32'd0);
        tick();
        bus_a.MemWrite = 1'b0;
        #1;
        chk("io_out_written", io_out_a, 32'h0000_00A5);
        chk("io_strobe_pulse", io_strobe_a, 32'd1);
        chk("io_readback", bus_a.memData, 32'h0000_00A5);
        tick();
        chk("io_strobe_one_cycle", io_strobe_a, 32'd0);
        chk("io_out_held", io_out_a, 32'h0000_00A5);

        // Asynchronous reset while running
        @(posedge clk);
        #3;
        rst_a = 1'b1;
        #1;
        chk("arst_run_cpu_reset", cpu_reset_a, 32'd1);
        chk("arst_run_io_out", io_out_a, 32'h0);
        chk("arst_run_load_ready", bus_a.load_ready, 32'd1);
        tick();
        rst_a = 1'b0;

        // Two beats, a core write that LOAD must ignore, then reset mid-load
        for (int i = 0; i < 2; i++) begin
            bus_a.load_valid = 1'b1;
            bus_a.load_data  = 32'h3000_0001 + i;
            bus_a.load_last  = 1'b0;
            tick();
        end
        bus_a.load_valid   = 1'b0;
        bus_a.memAddr      = 16'h0010;
        bus_a.MemWrite     = 1'b1;
        bus_a.writeMemData = 32'h0;
        tick();
        chk("load_core_write_strobe", io_strobe_a, 32'd0);
        rd_a(16'h0010, 32'hDEAD_BEEF, "load_core_write_ignored");
        rd_a(16'h0004, 32'h3000_0002, "load_visible_word1");
        chk("midload_ready", bus_a.load_ready, 32'd1);
        #1;
        rst_a = 1'b1;
        #1;
        chk("arst_load_cpu_reset", cpu_reset_a, 32'd1);
        tick();
        rst_a = 1'b0;

        bus_a.load_valid = 1'b1;
        bus_a.load_data  = 32'h4000_0001;
        bus_a.load_last  = 1'b1;
        tick();
        bus_a.load_valid = 1'b0;
        bus_a.load_last  = 1'b0;
        #1;
        chk("reload_cpu_reset", cpu_reset_a, 32'd0);
        rd_a(16'h0000, 32'h4000_0001, "reload_word0");
        rd_a(16'h0004, 32'h3000_0002, "reload_word1_kept");
        rd_a(16'h0008, 32'h2000_0003, "reload_word2_kept");
        rd_a(16'h000C, 32'h1000_0004, "reload_word3_kept");

        // Auto-finish on an 8-word array with no load_last
        tick();
        rst_b = 1'b0;
        #1;
        chk("b_rst_cpu_reset", cpu_reset_b, 32'd1);
        for (int i = 0; i < 10; i++) begin
            bus_b.load_valid = 1'b1;
            bus_b.load_data  = 32'h5000_0001 + i;
            bus_b.load_last  = 1'b0;
            #1;
            chk($sformatf("b_ready_beat_%0d", i + 1), bus_b.load_ready, (i < 8) ? 32'd1 : 32'd0);
            tick();
            if (i == 7) chk("b_cpu_reset_after_8", cpu_reset_b, 32'd0);
        end
        bus_b.load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_b(16'(i * 4), 32'h5000_0001 + i, $sformatf("b_word_%0d", i));
        end
        rd_b(16'h0020, 32'h0, "b_unmapped_word8");
        chk("b_io_strobe", io_strobe_b, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
